// File: rtl/pulser_pkg.sv
// Shared widths and state encoding for the pulse mean-square path.
// MS_W matches the z input width of the downstream root stage.
package pulser_pkg;
  localparam int SAMPLE_W = 8;
  localparam int SQ_W     = 15;
  localparam int MS_W     = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/mean_square_acc_squarer.sv
// Combinational signed-sample squarer: 0 cycles, no flow control.
// Squaring the magnitude keeps the product unsigned and exactly SQ_W wide.
module sample_squarer
  import pulser_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [SQ_W-1:0]     sq
);
  logic [SAMPLE_W-1:0] w_mag;

  // -128 maps to 8'h80, read as unsigned 128, so the magnitude never overflows.
  assign w_mag = sample[SAMPLE_W-1] ? (~sample + 1'b1) : sample;
  assign sq    = SQ_W'(w_mag) * SQ_W'(w_mag);
endmodule

// File: rtl/mean_square_acc.sv
// Windowed mean square of 2^LOG2N samples; result valid 1 cycle after last accept.
// While a result is held, in_ready is low and inputs are ignored until out_ready.
module mean_square_acc
  import pulser_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic        [MS_W-1:0]     ms_out,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = SQ_W + LOG2N;
  localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [MS_W-1:0]   r_ms;

  logic [SQ_W-1:0]   w_sq;
  logic [ACC_W-1:0]  w_sum;
  logic              w_last;

  sample_squarer u_sq (
    .sample (sample),
    .sq     (w_sq)
  );

  assign w_sum  = r_acc + ACC_W'(w_sq);
  // With LOG2N=0 the counter is pinned at 0, so every accept is the last.
  assign w_last = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ms    <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (in_valid) begin
            if (w_last) begin
              r_ms    <= MS_W'(w_sum >> LOG2N);
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign ms_out    = r_ms;
endmodule

// File: tb/tb_mean_square_acc.sv
// Directed bench: LOG2N=4 instance driven from a vector table plus corner sequences,
// and a LOG2N=0 instance sharing the same inputs for the single-sample window case.
module tb_mean_square_acc;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic signed [7:0] sample;
  logic              in_valid;
  logic              out_ready;

  logic        in_ready,  out_valid;
  logic [15:0] ms_out;
  logic        in_ready0, out_valid0;
  logic [15:0] ms_out0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mean_square_acc #(.LOG2N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sample    (sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ms_out    (ms_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mean_square_acc #(.LOG2N(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sample    (sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .ms_out    (ms_out0),
    .out_valid (out_valid0),
    .out_ready (out_ready)
  );

  // mode 0: constant a; mode 1: ramp a, a+1, ...; mode 2: alternate a, -a.
  typedef struct {
    int mode;
    int a;
    int exp_ms;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int smp_val(input int mode, input int a, input int i);
    case (mode)
      1:       return a + i;
      2:       return (i % 2 == 0) ? a : -a;
      default: return a;
    endcase
  endfunction

  // Called at a negedge with the DUT in ACCUM; returns at the negedge after
  // the 16th accept, where the result must already be visible.
  task automatic run_window(input string name, input int mode, input int a, input int exp_ms);
    for (int i = 0; i < 16; i++) begin
      sample   = 8'(smp_val(mode, a, i));
      in_valid = 1'b1;
      if (!in_ready) chk({name, " in_ready_during_window"}, int'(in_ready), 1);
      if (i == 15) chk({name, " out_valid_before_last"}, int'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({name, " out_valid"}, int'(out_valid), 1);
    chk({name, " ms_out"}, int'(ms_out), exp_ms);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0,    3,     9};
    vecs[1] = '{0, -128, 16384};
    vecs[2] = '{1,    0,    77};
    vecs[3] = '{2,   10,   100};
    vecs[4] = '{0,    0,     0};
    vecs[5] = '{0,  127, 16129};
    vecs[6] = '{1,   -8,    21};

    rst_n = 1'b0; clear = 1'b0; sample = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset ms_out", int'(ms_out), 0);
    chk("reset0 out_valid", int'(out_valid0), 0);

    for (int v = 0; v < 7; v++) begin
      run_window($sformatf("vec%0d", v), vecs[v].mode, vecs[v].a, vecs[v].exp_ms);
      @(negedge clk);
      chk($sformatf("vec%0d transfer out_valid", v), int'(out_valid), 0);
      chk($sformatf("vec%0d transfer in_ready", v), int'(in_ready), 1);
    end

    // Backpressure: result held while inputs are offered and refused.
    out_ready = 1'b0;
    run_window("bp", 0, 7, 49);
    sample = 8'sd50; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp ms_stable", int'(ms_out), 49);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", int'(in_ready), 1);
    chk("bp release out_valid", int'(out_valid), 0);
    chk("bp ms_kept", int'(ms_out), 49);
    in_valid = 1'b0;
    run_window("bp_next", 0, 2, 4);
    @(negedge clk);

    // Clear mid-window drops partial sum and the coincident sample.
    for (int k = 0; k < 7; k++) begin
      sample = 8'sd100; in_valid = 1'b1;
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    run_window("clr", 0, 5, 25);
    @(negedge clk);

    // Clear in HOLD must not disturb the pending result.
    out_ready = 1'b0;
    run_window("hold", 0, 4, 16);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("hold_clear out_valid", int'(out_valid), 1);
    chk("hold_clear ms_out", int'(ms_out), 16);

    // Reset while holding a result discards it.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hold out_valid", int'(out_valid), 0);
    chk("rst_hold ms_out", int'(ms_out), 0);
    chk("rst_hold in_ready", int'(in_ready), 1);

    // Single-sample window on the LOG2N=0 instance.
    sample = -8'sd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("n1 out_valid", int'(out_valid0), 1);
    chk("n1 ms_out", int'(ms_out0), 49);
    chk("n1 in_ready", int'(in_ready0), 0);
    chk("n16 not_done", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
